// File: rtl/golden_epoch_arbiter.sv
// Registered two-input flit arbiter: golden-packet priority for forward progress,
// round-robin among non-golden contenders, plus the epoch counter that advances golden_id.
module golden_epoch_arbiter #(
  parameter int FLIT_W    = 32,
  parameter int PKT_LSB   = 8,
  parameter int PKT_W     = 8,
  parameter int SEQ_LSB   = 0,
  parameter int SEQ_W     = 4,
  parameter int EPOCH_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [FLIT_W-1:0] in0_flit,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [FLIT_W-1:0] in1_flit,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  input  logic              out_ready,
  output logic [PKT_W-1:0]  golden_id
);

  localparam int CNT_W = $clog2(EPOCH_LEN);

  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  epoch_cnt_q, epoch_cnt_d;
  logic [PKT_W-1:0]  golden_id_q, golden_id_d;

  logic             load, contend, gold0, gold1, pick1, grant0, grant1;
  logic [SEQ_W-1:0] seq0, seq1;

  always_comb begin
    load    = !out_valid_q || out_ready;
    contend = in0_valid && in1_valid;
    gold0   = (in0_flit[PKT_LSB +: PKT_W] == golden_id_q);
    gold1   = (in1_flit[PKT_LSB +: PKT_W] == golden_id_q);
    seq0    = in0_flit[SEQ_LSB +: SEQ_W];
    seq1    = in1_flit[SEQ_LSB +: SEQ_W];

    pick1 = in1_valid;
    if (contend) begin
      if (gold0 != gold1) begin
        pick1 = gold1;
      end else if (gold0) begin
        pick1 = (seq1 < seq0);
      end else begin
        pick1 = rr_q;
      end
    end

    // Grants are suppressed while reset is held so nothing is consumed upstream.
    grant0 = !rst && load && in0_valid && !pick1;
    grant1 = !rst && load && in1_valid && pick1;

    out_valid_d = load ? (grant0 || grant1) : out_valid_q;
    out_flit_d  = out_flit_q;
    if (grant1) begin
      out_flit_d = in1_flit;
    end else if (grant0) begin
      out_flit_d = in0_flit;
    end

    rr_d = rr_q;
    if (contend && !gold0 && !gold1 && (grant0 || grant1)) begin
      rr_d = !rr_q;
    end

    // Epoch wrap is free-running and never waits on traffic.
    epoch_cnt_d = epoch_cnt_q + CNT_W'(1);
    golden_id_d = golden_id_q;
    if (epoch_cnt_q == CNT_W'(EPOCH_LEN - 1)) begin
      epoch_cnt_d = '0;
      golden_id_d = golden_id_q + PKT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      rr_q        <= 1'b0;
      epoch_cnt_q <= '0;
      golden_id_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      rr_q        <= rr_d;
      epoch_cnt_q <= epoch_cnt_d;
      golden_id_q <= golden_id_d;
    end
  end

  assign in0_ready = grant0;
  assign in1_ready = grant1;
  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign golden_id = golden_id_q;

endmodule
